btn_debounce_multi: RTL and testbench

//  N-channel push-button conditioner between board pins and control FSMs/UI logic.
//  Per channel: 2-FF synchroniser, tick-sampled shift-register debounce with hysteresis,
//  and one-clk pulses for press, release, long-press and auto-repeat.

---
 rtl/btn_debounce_multi.sv | 126 ++++++++++++
 tb/tb_btn_debounce_multi.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, tick-sampled debounce with hysteresis,
// and one-clock press/release/long/repeat pulses per channel, all in one clock domain.
`timescale 1ns/1ps
module btn_debounce_multi #(
    parameter int N_BTN        = 5,
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1_000,
    parameter int DEPTH        = 8,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_long,
    output logic [N_BTN-1:0] o_repeat,
    output logic             o_tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(LONG_TICKS + REPEAT_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(LONG_TICKS + REPEAT_TICKS);

    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [DEPTH-2:0] r_hist   [N_BTN];
    logic [DEPTH-1:0] w_window [N_BTN];
    logic [CNT_W-1:0] r_hold   [N_BTN];
    logic [CNT_W-1:0] w_holdInc[N_BTN];
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic [N_BTN-1:0] r_long;
    logic [N_BTN-1:0] r_repeat;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // The window is the post-shift register value: newest sample on top, oldest one drops off
    // the bottom, so only DEPTH-1 past samples need storing.
    always_comb begin
        for (int c = 0; c < N_BTN; c++) begin
            w_window[c]  = {r_sync2[c], r_hist[c]};
            w_holdInc[c] = r_hold[c] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_BTN; c++) begin
                r_hist[c] <= '0;
                r_hold[c] <= '0;
            end
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
            r_repeat  <= '0;
        end else begin
            r_press   <= '0;
            r_release <= '0;
            r_long    <= '0;
            r_repeat  <= '0;
            if (w_tick) begin
                for (int c = 0; c < N_BTN; c++) begin
                    r_hist[c] <= w_window[c][DEPTH-1:1];
                    if ((&w_window[c]) && !r_level[c]) begin
                        r_level[c] <= 1'b1;
                        r_press[c] <= 1'b1;
                    end else if (!(|w_window[c]) && r_level[c]) begin
                        r_level[c]   <= 1'b0;
                        r_release[c] <= 1'b1;
                        r_hold[c]    <= '0;
                    end else if (r_level[c]) begin
                        // Repeat reloads to LONG so the count never overflows; with no repeat it saturates.
                        if ((REPEAT_TICKS > 0) && (w_holdInc[c] == CNT_TOP)) begin
                            r_repeat[c] <= 1'b1;
                            r_hold[c]   <= CNT_LONG;
                        end else if ((REPEAT_TICKS > 0) || (r_hold[c] != CNT_LONG)) begin
                            r_hold[c] <= w_holdInc[c];
                            if (w_holdInc[c] == CNT_LONG) begin
                                r_long[c] <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;
    assign o_tick    = w_tick;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench: two debouncers (repeat 3 and repeat disabled) on shared random stimulus,
// compared every clock against a tick/run-length reference model plus directed timing checks.
`timescale 1ns/1ps
module tb_btn_debounce_multi;

    localparam int N      = 2;
    localparam int DIV    = 10;
    localparam int DEPTH  = 4;
    localparam int LONG   = 5;
    localparam int REP_A  = 3;
    localparam int REP_B  = 0;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] i_btn = '0;

    logic [N-1:0] aLevel, aPress, aRelease, aLong, aRepeat;
    logic [N-1:0] bLevel, bPress, bRelease, bLong, bRepeat;
    logic         aTick, bTick;
    logic [31:0]  obsA, obsB;

    int  errors = 0;
    int  checks = 0;
    bit  checkEn = 1'b0;

    always #5 clk = ~clk;

    btn_debounce_multi #(.N_BTN(N), .CLK_HZ(1000), .TICK_HZ(100), .DEPTH(DEPTH),
                         .LONG_TICKS(LONG), .REPEAT_TICKS(REP_A)) dutA (
        .clk(clk), .reset(reset), .i_btn(i_btn), .o_level(aLevel), .o_press(aPress),
        .o_release(aRelease), .o_long(aLong), .o_repeat(aRepeat), .o_tick(aTick));

    btn_debounce_multi #(.N_BTN(N), .CLK_HZ(1000), .TICK_HZ(100), .DEPTH(DEPTH),
                         .LONG_TICKS(LONG), .REPEAT_TICKS(REP_B)) dutB (
        .clk(clk), .reset(reset), .i_btn(i_btn), .o_level(bLevel), .o_press(bPress),
        .o_release(bRelease), .o_long(bLong), .o_repeat(bRepeat), .o_tick(bTick));

    assign obsA = {21'd0, aLevel, aPress, aRelease, aLong, aRepeat, aTick};
    assign obsB = {21'd0, bLevel, bPress, bRelease, bLong, bRepeat, bTick};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a button is "settled" once its last DEPTH samples agree (run length),
    // and long/repeat come from the number of ticks held since the level went high.
    int  edgeCnt;
    logic [N-1:0] s1, s2;
    int  runVal [N];
    int  runLen [N];
    bit  mLevel [2][N];
    int  mHeld  [2][N];
    bit  mPress [2][N];
    bit  mRelease[2][N];
    bit  mLong  [2][N];
    bit  mRepeat[2][N];
    bit  expTick;

    function automatic int repOf(input int i);
        return (i == 0) ? REP_A : REP_B;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            edgeCnt = 0;
            s1 = '0;
            s2 = '0;
            expTick = 1'b0;
            for (int c = 0; c < N; c++) begin
                runVal[c] = 0;
                runLen[c] = DEPTH;
                for (int i = 0; i < 2; i++) begin
                    mLevel[i][c] = 0; mHeld[i][c] = 0; mPress[i][c] = 0;
                    mRelease[i][c] = 0; mLong[i][c] = 0; mRepeat[i][c] = 0;
                end
            end
        end else begin
            edgeCnt++;
            for (int c = 0; c < N; c++)
                for (int i = 0; i < 2; i++) begin
                    mPress[i][c] = 0; mRelease[i][c] = 0; mLong[i][c] = 0; mRepeat[i][c] = 0;
                end
            if (edgeCnt % DIV == 0) begin
                for (int c = 0; c < N; c++) begin
                    if (int'(s2[c]) == runVal[c]) runLen[c]++;
                    else begin runVal[c] = int'(s2[c]); runLen[c] = 1; end
                    for (int i = 0; i < 2; i++) begin
                        if (runLen[c] >= DEPTH && runVal[c] != int'(mLevel[i][c])) begin
                            mLevel[i][c] = (runVal[c] != 0);
                            if (runVal[c] != 0) mPress[i][c] = 1;
                            else mRelease[i][c] = 1;
                            mHeld[i][c] = 0;
                        end else if (mLevel[i][c]) begin
                            mHeld[i][c]++;
                            if (mHeld[i][c] == LONG) mLong[i][c] = 1;
                            if (repOf(i) > 0 && mHeld[i][c] > LONG && (mHeld[i][c] - LONG) % repOf(i) == 0)
                                mRepeat[i][c] = 1;
                        end
                    end
                end
            end
            s2 = s1;
            s1 = i_btn;
            expTick = (edgeCnt % DIV == DIV - 1);
        end
    end

    function automatic logic [31:0] expVec(input int i);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < N; c++) begin
            v[9+c] = mLevel[i][c];
            v[7+c] = mPress[i][c];
            v[5+c] = mRelease[i][c];
            v[3+c] = mLong[i][c];
            v[1+c] = mRepeat[i][c];
        end
        v[0] = expTick;
        return v;
    endfunction

    int cntPressA0, cntReleaseA0, cntLongA0, cntRepeatA0, cntLongB0, cntRepeatB0, cntCh1A;

    always @(posedge clk) begin
        #1;
        if (checkEn) begin
            checkOutput("modelA", obsA, expVec(0));
            checkOutput("modelB", obsB, expVec(1));
        end
        cntPressA0   += int'(aPress[0]);
        cntReleaseA0 += int'(aRelease[0]);
        cntLongA0    += int'(aLong[0]);
        cntRepeatA0  += int'(aRepeat[0]);
        cntLongB0    += int'(bLong[0]);
        cntRepeatB0  += int'(bRepeat[0]);
        cntCh1A      += int'(aLevel[1] | aPress[1] | aRelease[1] | aLong[1] | aRepeat[1]);
    end

    task automatic waitLevelA(input int ch, input logic val, input int budget, input string tag);
        int n;
        n = 0;
        while (aLevel[ch] !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, aLevel[ch]}, {31'd0, val});
    endtask

    // Returns just after the n-th upcoming tick edge has been processed.
    task automatic waitTicks(input int n);
        int seen, guard;
        seen = 0;
        guard = 0;
        while (seen < n && guard < n * DIV * 3) begin
            @(negedge clk);
            guard++;
            if (aTick) seen++;
        end
        @(negedge clk);
        if (seen != n) checkOutput("tickTimeout", 32'(seen), 32'(n));
    endtask

    task automatic applyStimulus(input int segments);
        for (int s = 0; s < segments; s++) begin
            i_btn = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < 6; b++) begin
                    i_btn[$urandom_range(0, 1)] ^= 1'b1;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                end
            end
            repeat ($urandom_range(1, 200)) @(negedge clk);
        end
    endtask

    initial begin
        int p0, l0, r0, rel0, lb, rb, c1, cyc, pressAt, longAt;

        // Reset state and tick placement
        repeat (2) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("resetA", obsA, 32'd0);
        checkOutput("resetB", obsB, 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checkOutput("tickPos", {31'd0, aTick}, (k % DIV == DIV - 1) ? 32'd1 : 32'd0);
        end

        // Bouncing press on channel 0, then held through long and repeats
        p0 = cntPressA0;
        c1 = cntCh1A;
        for (int b = 0; b < 7; b++) begin
            i_btn[0] = ~i_btn[0];
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        i_btn[0] = 1'b1;
        waitLevelA(0, 1'b1, 80, "bounceRise");
        l0 = cntLongA0; r0 = cntRepeatA0; rel0 = cntReleaseA0; lb = cntLongB0; rb = cntRepeatB0;
        waitTicks(11);
        i_btn[0] = 1'b0;
        waitLevelA(0, 1'b0, 100, "holdFall");
        waitTicks(2);
        checkOutput("bouncePressCnt", 32'(cntPressA0 - p0), 32'd1);
        checkOutput("holdLongCnt", 32'(cntLongA0 - l0), 32'd1);
        checkOutput("holdRepeatCnt", 32'(cntRepeatA0 - r0), 32'd3);
        checkOutput("holdReleaseCnt", 32'(cntReleaseA0 - rel0), 32'd1);
        checkOutput("noRepLongCnt", 32'(cntLongB0 - lb), 32'd1);
        checkOutput("noRepRepeatCnt", 32'(cntRepeatB0 - rb), 32'd0);
        checkOutput("ch1Quiet", 32'(cntCh1A - c1), 32'd0);

        // One-sample glitches while held and while released
        i_btn[0] = 1'b1;
        waitLevelA(0, 1'b1, 80, "glitchRise");
        waitTicks(1);
        p0 = cntPressA0; rel0 = cntReleaseA0;
        i_btn[0] = 1'b0;
        repeat (DIV) @(negedge clk);
        i_btn[0] = 1'b1;
        waitTicks(6);
        checkOutput("lowGlitchLevel", {31'd0, aLevel[0]}, 32'd1);
        checkOutput("lowGlitchEdges", 32'((cntPressA0 - p0) + (cntReleaseA0 - rel0)), 32'd0);
        i_btn[0] = 1'b0;
        waitLevelA(0, 1'b0, 80, "glitchFall");
        waitTicks(1);
        p0 = cntPressA0 + cntReleaseA0 + cntLongA0 + cntRepeatA0;
        i_btn[0] = 1'b1;
        repeat (DIV) @(negedge clk);
        i_btn[0] = 1'b0;
        waitTicks(6);
        checkOutput("highGlitchLevel", {31'd0, aLevel[0]}, 32'd0);
        checkOutput("highGlitchPulses",
                    32'(cntPressA0 + cntReleaseA0 + cntLongA0 + cntRepeatA0 - p0), 32'd0);

        // Long hold: repeat every 3 ticks on A, single long only on B
        i_btn[0] = 1'b1;
        waitLevelA(0, 1'b1, 80, "longRise");
        r0 = cntRepeatA0; lb = cntLongB0; rb = cntRepeatB0;
        waitTicks(20);
        checkOutput("hold20RepeatA", 32'(cntRepeatA0 - r0), 32'd5);
        checkOutput("hold20LongB", 32'(cntLongB0 - lb), 32'd1);
        checkOutput("hold20RepeatB", 32'(cntRepeatB0 - rb), 32'd0);
        i_btn[0] = 1'b0;
        waitLevelA(0, 1'b0, 80, "longFall");

        // Reset in the middle of a hold, button kept pressed across it
        i_btn[0] = 1'b1;
        waitLevelA(0, 1'b1, 80, "midRise");
        waitTicks(4);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midResetA", obsA, 32'd0);
        checkOutput("midResetB", obsB, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0; pressAt = -1; longAt = -1;
        while (longAt < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (aPress[0] && pressAt < 0) pressAt = cyc;
            if (aLong[0]) longAt = cyc;
        end
        checkOutput("afterResetPressAt", 32'(pressAt), 32'(DEPTH * DIV));
        checkOutput("afterResetLongAt", 32'(longAt), 32'((DEPTH + LONG) * DIV));
        i_btn[0] = 1'b0;
        waitLevelA(0, 1'b0, 80, "afterResetFall");

        // Random traffic on both channels
        applyStimulus(40);
        i_btn = '0;
        repeat (100) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
